// File: rtl/decision_tree_top_if.sv
// Command and motion bundle between the Arduino link, the planner and the
// motor-drive stage. The slave side is the drive-command block itself.
interface decision_tree_top_if;
  logic [7:0] arduino_command;
  logic [3:0] auto_dir;
  logic       manual_on;
  logic       auto_on;
  logic       w;
  logic       s;
  logic       a;
  logic       d;
  logic       wa;
  logic       wd;
  logic       as;
  logic       ds;
  logic       stop;

  modport master (
    output arduino_command, auto_dir,
    input  manual_on, auto_on, w, s, a, d, wa, wd, as, ds, stop
  );

  modport slave (
    input  arduino_command, auto_dir,
    output manual_on, auto_on, w, s, a, d, wa, wd, as, ds, stop
  );
endinterface

// File: rtl/decision_tree_top.sv
// Rover drive-command block: registers the Arduino command byte, tracks
// IDLE/MANUAL/AUTO mode and drives nine registered one-hot motion outputs,
// decoded from the command byte (MANUAL) or the planner direction (AUTO).
module decision_tree_top (
  input logic                  CLOCK_50,
  input logic                  reset,
  decision_tree_top_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MANUAL = 2'd1,
    AUTO   = 2'd2
  } state_t;

  // Motion vector bit order: {stop, ds, as, wd, wa, d, a, s, w}
  localparam logic [8:0] M_W    = 9'h001;
  localparam logic [8:0] M_S    = 9'h002;
  localparam logic [8:0] M_A    = 9'h004;
  localparam logic [8:0] M_D    = 9'h008;
  localparam logic [8:0] M_WA   = 9'h010;
  localparam logic [8:0] M_WD   = 9'h020;
  localparam logic [8:0] M_AS   = 9'h040;
  localparam logic [8:0] M_DS   = 9'h080;
  localparam logic [8:0] M_STOP = 9'h100;

  localparam logic [7:0] CMD_MANUAL = 8'h00;
  localparam logic [7:0] CMD_AUTO   = 8'hFF;

  state_t     r_state;
  state_t     w_next_state;
  logic [7:0] r_cmd_q;
  logic       r_cmd_valid;
  logic       r_manual_on;
  logic       r_auto_on;
  logic [8:0] r_motion;
  logic [8:0] w_motion;

  // Exact 8-bit match; anything not in the table halts the motors.
  function automatic logic [8:0] f_decode(input logic [7:0] code);
    logic [8:0] m;
    case (code)
      8'h01:   m = M_W;
      8'h04:   m = M_S;
      8'h02:   m = M_A;
      8'h08:   m = M_D;
      8'h03:   m = M_WA;
      8'h09:   m = M_WD;
      8'h05:   m = M_AS;
      8'h0C:   m = M_DS;
      default: m = M_STOP;
    endcase
    return m;
  endfunction

  // Input stage: capture the command byte every cycle. r_cmd_valid marks
  // that r_cmd_q holds a byte sampled after reset release, so the reset
  // value of 0x00 can never be mistaken for a MANUAL request.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_cmd_q     <= '0;
      r_cmd_valid <= 1'b0;
    end else begin
      r_cmd_q     <= bus.arduino_command;
      r_cmd_valid <= 1'b1;
    end
  end

  // Mode transition from the registered command byte.
  always_comb begin
    w_next_state = r_state;
    if (r_cmd_valid) begin
      case (r_state)
        IDLE: begin
          if (r_cmd_q == CMD_MANUAL)
            w_next_state = MANUAL;
          else if (r_cmd_q == CMD_AUTO)
            w_next_state = AUTO;
        end
        MANUAL: begin
          if (r_cmd_q == CMD_AUTO)
            w_next_state = AUTO;
        end
        AUTO: begin
          if (r_cmd_q == CMD_MANUAL)
            w_next_state = MANUAL;
        end
        default: w_next_state = IDLE;
      endcase
    end
  end

  // Motion source follows the mode being entered, so a mode change and its
  // first motion decode land on the same edge.
  always_comb begin
    w_motion = M_STOP;
    case (w_next_state)
      MANUAL:  w_motion = f_decode(r_cmd_q);
      AUTO:    w_motion = f_decode({4'h0, bus.auto_dir});
      default: w_motion = M_STOP;
    endcase
  end

  // Mode FSM with registered mode and motion outputs.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_manual_on <= 1'b0;
      r_auto_on   <= 1'b0;
      r_motion    <= M_STOP;
    end else begin
      r_state     <= w_next_state;
      r_manual_on <= (w_next_state == MANUAL);
      r_auto_on   <= (w_next_state == AUTO);
      r_motion    <= w_motion;
    end
  end

  assign bus.manual_on = r_manual_on;
  assign bus.auto_on   = r_auto_on;
  assign bus.w         = r_motion[0];
  assign bus.s         = r_motion[1];
  assign bus.a         = r_motion[2];
  assign bus.d         = r_motion[3];
  assign bus.wa        = r_motion[4];
  assign bus.wd        = r_motion[5];
  assign bus.as        = r_motion[6];
  assign bus.ds        = r_motion[7];
  assign bus.stop      = r_motion[8];

endmodule

// File: tb/tb_decision_tree_top.sv
// Bench for decision_tree_top: directed vector table plus hand-written
// sequences for reset release, latency and asynchronous reset.
module tb_decision_tree_top;

  localparam logic [8:0] M_W    = 9'h001;
  localparam logic [8:0] M_S    = 9'h002;
  localparam logic [8:0] M_A    = 9'h004;
  localparam logic [8:0] M_D    = 9'h008;
  localparam logic [8:0] M_WA   = 9'h010;
  localparam logic [8:0] M_WD   = 9'h020;
  localparam logic [8:0] M_AS   = 9'h040;
  localparam logic [8:0] M_DS   = 9'h080;
  localparam logic [8:0] M_STOP = 9'h100;

  typedef struct {
    logic [7:0] cmd;
    logic [3:0] adir;
    logic       man;
    logic       aut;
    logic [8:0] mot;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  vec_t tbl[$];
  logic [8:0] got_mot;

  always #10 clk = ~clk;

  decision_tree_top_if bus ();

  decision_tree_top dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .bus      (bus)
  );

  assign got_mot = {bus.stop, bus.ds, bus.as, bus.wd, bus.wa,
                    bus.d, bus.a, bus.s, bus.w};

  task automatic check_out(input string nm, input logic man, input logic aut,
                           input logic [8:0] mot);
    checks++;
    if ({bus.manual_on, bus.auto_on, got_mot} !== {man, aut, mot}) begin
      errors++;
      $display("FAIL %s: got manual_on=%b auto_on=%b motion=%09b, want manual_on=%b auto_on=%b motion=%09b",
               nm, bus.manual_on, bus.auto_on, got_mot, man, aut, mot);
    end
  endtask

  task automatic check_onehot();
    checks++;
    if ($countones(got_mot) != 1 || (bus.manual_on && bus.auto_on) ||
        $isunknown({bus.manual_on, bus.auto_on, got_mot})) begin
      errors++;
      $display("FAIL onehot @%0t: got manual_on=%b auto_on=%b motion=%09b, want one motion bit and exclusive modes",
               $time, bus.manual_on, bus.auto_on, got_mot);
    end
  endtask

  // Advance n rising edges, checking one-hot at each following falling edge.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
      check_onehot();
    end
  endtask

  initial begin
    // Directed vectors, all applied starting from MANUAL mode.
    tbl.push_back('{8'h01, 4'h0, 1'b1, 1'b0, M_W});
    tbl.push_back('{8'h04, 4'h0, 1'b1, 1'b0, M_S});
    tbl.push_back('{8'h02, 4'h0, 1'b1, 1'b0, M_A});
    tbl.push_back('{8'h08, 4'h0, 1'b1, 1'b0, M_D});
    tbl.push_back('{8'h03, 4'h0, 1'b1, 1'b0, M_WA});
    tbl.push_back('{8'h09, 4'h0, 1'b1, 1'b0, M_WD});
    tbl.push_back('{8'h05, 4'h0, 1'b1, 1'b0, M_AS});
    tbl.push_back('{8'h0C, 4'h0, 1'b1, 1'b0, M_DS});
    tbl.push_back('{8'h10, 4'h0, 1'b1, 1'b0, M_STOP});
    tbl.push_back('{8'h06, 4'h0, 1'b1, 1'b0, M_STOP});
    tbl.push_back('{8'h0F, 4'h0, 1'b1, 1'b0, M_STOP});
    tbl.push_back('{8'h00, 4'h0, 1'b1, 1'b0, M_STOP});
    tbl.push_back('{8'hFF, 4'h1, 1'b0, 1'b1, M_W});
    tbl.push_back('{8'h01, 4'h1, 1'b0, 1'b1, M_W});
    tbl.push_back('{8'h01, 4'h8, 1'b0, 1'b1, M_D});

    // Reset state, held over several clock edges.
    rst = 1'b1;
    bus.arduino_command = 8'h01;
    bus.auto_dir = 4'h0;
    repeat (3) @(negedge clk);
    check_out("reset_state", 1'b0, 1'b0, M_STOP);
    check_onehot();

    // Release with a non-zero code: the reset 0x00 in cmd_q must not move
    // IDLE to MANUAL, and 0x01 in IDLE stays in IDLE.
    rst = 1'b0;
    tick(1);
    check_out("release_edge1_idle", 1'b0, 1'b0, M_STOP);
    tick(1);
    check_out("idle_0x01_stays", 1'b0, 1'b0, M_STOP);

    // 0x00 enters MANUAL two edges after it is applied.
    bus.arduino_command = 8'h00;
    tick(1);
    check_out("to_manual_edge1", 1'b0, 1'b0, M_STOP);
    tick(1);
    check_out("to_manual_edge2", 1'b1, 1'b0, M_STOP);

    // Two-edge latency of a manual code.
    bus.arduino_command = 8'h01;
    tick(1);
    check_out("lat_w_edge1", 1'b1, 1'b0, M_STOP);
    tick(1);
    check_out("lat_w_edge2", 1'b1, 1'b0, M_W);

    // Table sweep: each vector held for 50 ns or longer.
    for (int i = 0; i < tbl.size(); i++) begin
      bus.arduino_command = tbl[i].cmd;
      bus.auto_dir        = tbl[i].adir;
      tick(3);
      check_out($sformatf("vec%0d_cmd%02h_dir%h", i, tbl[i].cmd, tbl[i].adir),
                tbl[i].man, tbl[i].aut, tbl[i].mot);
    end

    // In AUTO: auto_dir reaches the outputs one edge after it changes.
    bus.auto_dir = 4'h3;
    tick(1);
    check_out("auto_dir_lat1", 1'b0, 1'b1, M_WA);
    bus.auto_dir = 4'hF;
    tick(1);
    check_out("auto_dir_invalid", 1'b0, 1'b1, M_STOP);
    bus.auto_dir = 4'hC;
    tick(1);
    check_out("auto_dir_ds", 1'b0, 1'b1, M_DS);

    // AUTO -> MANUAL on 0x00 after two edges, mode and motion together.
    bus.arduino_command = 8'h00;
    tick(1);
    check_out("auto_exit_edge1", 1'b0, 1'b1, M_DS);
    tick(1);
    check_out("auto_exit_edge2", 1'b1, 1'b0, M_STOP);

    bus.arduino_command = 8'h01;
    tick(2);
    check_out("manual_w_again", 1'b1, 1'b0, M_W);

    // Asynchronous reset mid-command, checked before any clock edge.
    #3 rst = 1'b1;
    #1 check_out("async_reset", 1'b0, 1'b0, M_STOP);
    tick(2);
    check_out("reset_held", 1'b0, 1'b0, M_STOP);

    // Release with 0x00 applied: MANUAL two edges later.
    bus.arduino_command = 8'h00;
    rst = 1'b0;
    tick(1);
    check_out("rel2_edge1", 1'b0, 1'b0, M_STOP);
    tick(1);
    check_out("rel2_edge2", 1'b1, 1'b0, M_STOP);

    // IDLE -> AUTO directly on 0xFF, motion from auto_dir on entry.
    rst = 1'b1;
    tick(1);
    bus.arduino_command = 8'hFF;
    bus.auto_dir = 4'h5;
    rst = 1'b0;
    tick(1);
    check_out("idle_auto_edge1", 1'b0, 1'b0, M_STOP);
    tick(1);
    check_out("idle_auto_edge2", 1'b0, 1'b1, M_AS);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Time limit so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL timeout: got no completion by %0t, want completion", $time);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
